// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester arbiter for a shared cache-line memory bus.
// Requests are granted round-robin from IDLE. A write streams BEATS beats to
// memory, each beat registered one cycle behind its wack. A read issues one
// READ_LINE cycle and then collects BEATS RESPONSE beats.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a read watchdog. It ends a
// read that stalls for TIMEOUT cycles, pulses done to the owner and raises err.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              m0_wack,
    output logic              m1_wack,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              m0_done,
    output logic              m1_done,
    output logic [1:0]        mem_cmd_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_drive,
    input  logic [1:0]        mem_cmd_in,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam logic [1:0] CMD_NOP        = 2'd0;
    localparam logic [1:0] CMD_RESPONSE   = 2'd1;
    localparam logic [1:0] CMD_READ_LINE  = 2'd2;
    localparam logic [1:0] CMD_WRITE_LINE = 2'd3;
    localparam int         CNT_W          = $clog2(BEATS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ISSUE,
        ST_WAIT,
        ST_READ
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;       // 0 = requester 0, 1 = requester 1
    logic             last_grant;  // requester granted most recently
    logic             trail;       // WRITE: trailing beat cycle after the last wack
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       grant_q;
    logic [1:0]       rvalid_q;
    logic [1:0]       done_q;
    logic [1:0]       owner_oh;
    logic             req0;
    logic             req1;
    logic             pick1;
    logic             any_req;
    logic [1:0]       win_cmd;
    logic             resp;
    logic             last_beat;
    logic             in_read;
    logic             time_out;

    assign req0      = (m0_cmd != CMD_NOP);
    assign req1      = (m1_cmd != CMD_NOP);
    assign any_req   = req0 | req1;
    // On contention the requester not granted last wins.
    assign pick1     = req1 && (!req0 || !last_grant);
    assign win_cmd   = pick1 ? m1_cmd : m0_cmd;
    assign resp      = (mem_cmd_in == CMD_RESPONSE);
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign in_read   = (state == ST_WAIT) || (state == ST_READ);
    assign owner_oh  = owner ? 2'b10 : 2'b01;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;

    assign time_out = in_read && !resp && (to_cnt == TO_W'(TIMEOUT - 1));

    // Watchdog: counts stalled WAIT/READ cycles, cleared by every RESPONSE beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (in_read && !resp && !time_out) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign time_out = 1'b0;
`endif

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = (win_cmd == CMD_WRITE_LINE) ? ST_WRITE : ST_ISSUE;
                end
            end
            ST_WRITE: begin
                if (trail) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT, ST_READ: begin
                if (resp) begin
                    state_next = last_beat ? ST_IDLE : ST_READ;
                end else if (time_out) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus-side outputs decoded from the current state.
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        mem_drive   = 1'b0;
        mem_cmd_out = CMD_NOP;
        m0_wack     = 1'b0;
        m1_wack     = 1'b0;
        case (state)
            ST_WRITE: begin
                mem_drive   = 1'b1;
                mem_cmd_out = CMD_WRITE_LINE;
                if (!trail) begin
                    m0_wack = !owner;
                    m1_wack = owner;
                end
            end
            ST_ISSUE: begin
                mem_drive   = 1'b1;
                mem_cmd_out = CMD_READ_LINE;
            end
            default: ;
        endcase
    end

    // Datapath: grant latching, beat counting, data registers and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            trail      <= 1'b0;
            beat_cnt   <= '0;
            grant_q    <= '0;
            rvalid_q   <= '0;
            done_q     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err        <= 1'b0;
`endif
        end else begin
            grant_q  <= '0;
            rvalid_q <= '0;
            done_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err      <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q    <= pick1 ? 2'b10 : 2'b01;
                        owner      <= pick1;
                        last_grant <= pick1;
                        mem_addr   <= pick1 ? m1_addr : m0_addr;
                    end
                end
                ST_WRITE: begin
                    if (!trail) begin
                        mem_wdata <= owner ? m1_wdata : m0_wdata;
                        beat_cnt  <= beat_cnt + CNT_W'(1);
                        if (last_beat) begin
                            trail <= 1'b1;
                        end
                    end else begin
                        trail  <= 1'b0;
                        done_q <= owner_oh;
                    end
                end
                ST_WAIT, ST_READ: begin
                    if (resp) begin
                        rdata    <= mem_rdata;
                        rvalid_q <= owner_oh;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (last_beat) begin
                            done_q <= owner_oh;
                        end
                    end else if (time_out) begin
                        done_q   <= owner_oh;
                        beat_cnt <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        err      <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_grant  = grant_q[0];
    assign m1_grant  = grant_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Expected behaviour is derived from
// the transfer timeline: cycle k counts from the grant cycle (k = 1).
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int BEATS   = 8;
    localparam int TIMEOUT = 20;
    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        m0_cmd = NOP, m1_cmd = NOP;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
    logic              m0_grant, m1_grant, m0_wack, m1_wack;
    logic              m0_rvalid, m1_rvalid, m0_done, m1_done;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        mem_cmd_out;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_drive;
    logic [1:0]        mem_cmd_in = NOP;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    logic              err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] beat_data [BEATS];

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BEATS  (BEATS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_cmd     (m0_cmd),
        .m1_cmd     (m1_cmd),
        .m0_addr    (m0_addr),
        .m1_addr    (m1_addr),
        .m0_wdata   (m0_wdata),
        .m1_wdata   (m1_wdata),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .m0_wack    (m0_wack),
        .m1_wack    (m1_wack),
        .m0_rvalid  (m0_rvalid),
        .m1_rvalid  (m1_rvalid),
        .rdata      (rdata),
        .m0_done    (m0_done),
        .m1_done    (m1_done),
        .mem_cmd_out(mem_cmd_out),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_drive  (mem_drive),
        .mem_cmd_in (mem_cmd_in),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {grant, wack, rvalid, done} of one requester.
    function automatic logic [3:0] sig_of(input int who);
        return (who == 1) ? {m1_grant, m1_wack, m1_rvalid, m1_done}
                          : {m0_grant, m0_wack, m0_rvalid, m0_done};
    endfunction

    task automatic drive_req(input int who, input logic [1:0] cmd, input logic [ADDR_W-1:0] addr);
        if (who == 1) begin
            m1_cmd  = cmd;
            m1_addr = addr;
        end else begin
            m0_cmd  = cmd;
            m0_addr = addr;
        end
    endtask

    task automatic drive_wdata(input int who, input logic [DATA_W-1:0] d);
        if (who == 1) m1_wdata = d;
        else          m0_wdata = d;
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {sig_of(0), sig_of(1), mem_drive, mem_cmd_out}, '0);
`ifdef MEM_ARB_TIMEOUT_EN
        check({tag, "_err"}, err, 0);
`endif
    endtask

    // Write line: grant at k=1, wack k=1..BEATS, bus driven k=1..BEATS+1,
    // beat i on mem_wdata at k=i+2, done at k=BEATS+2, idle afterwards.
    task automatic run_write(input int who, input logic [ADDR_W-1:0] addr);
        logic [3:0] o;
        drive_req(who, WR, addr);
        for (int k = 1; k <= BEATS + 3; k++) begin
            @(negedge clk);
            o = sig_of(who);
            check("wr_owner", o, {k == 1, k <= BEATS, 1'b0, k == BEATS + 2});
            check("wr_other", sig_of(1 - who), 0);
            check("wr_bus", {mem_drive, mem_cmd_out},
                  (k <= BEATS + 1) ? {1'b1, WR} : {1'b0, NOP});
            if (k >= 2 && k <= BEATS + 1) check("wr_wdata", mem_wdata, beat_data[k-2]);
            if (k <= BEATS + 1) check("wr_addr", mem_addr, addr);
            drive_wdata(1 - who, DATA_W'($urandom));
            if (k <= BEATS) begin
                drive_req(who, 2'($urandom), ADDR_W'($urandom));
                drive_wdata(who, beat_data[k-1]);
            end else begin
                drive_req(who, NOP, '0);
                drive_wdata(who, DATA_W'($urandom));
            end
        end
    endtask

    // Read line: ISSUE at k=1, each RESPONSE cycle yields rvalid one cycle
    // later; done coincides with the BEATS-th rvalid.
    // gap_mode: 0 back-to-back, 1 alternate beat/idle, 2 random gaps.
    task automatic run_read(input int who, input logic [ADDR_W-1:0] addr,
                            input int first_delay, input int gap_mode);
        logic [3:0] o;
        logic       pend = 1'b0;
        logic       go;
        logic [1:0] junk;
        int         sent = 0;
        int         got  = 0;
        bit         tail = 1'b0;
        bit         fin  = 1'b0;
        drive_req(who, RD, addr);
        for (int k = 1; k <= 200 && !fin; k++) begin
            @(negedge clk);
            o = sig_of(who);
            check("rd_owner", o, {k == 1, 1'b0, pend, pend && (got == BEATS - 1)});
            check("rd_other", sig_of(1 - who), 0);
            check("rd_bus", {mem_drive, mem_cmd_out}, (k == 1) ? {1'b1, RD} : {1'b0, NOP});
`ifdef MEM_ARB_TIMEOUT_EN
            check("rd_err", err, 0);
`endif
            if (k == 1) check("rd_addr", mem_addr, addr);
            if (pend) begin
                check("rd_data", rdata, beat_data[got]);
                got++;
            end
            if (got == BEATS) begin
                if (tail) fin = 1'b1;
                tail = 1'b1;
            end
            go = (k >= 1 + first_delay) && (k >= 2) && (sent < BEATS)
                 && (gap_mode != 1 || !pend)
                 && (gap_mode != 2 || $urandom_range(0, 2) != 0);
            if (go) begin
                mem_cmd_in = RESP;
                mem_rdata  = beat_data[sent];
                sent++;
            end else begin
                junk = 2'($urandom);
                mem_cmd_in = (junk == RESP) ? NOP : junk;
                mem_rdata  = DATA_W'($urandom);
            end
            pend = go;
            if (k == 1) drive_req(who, NOP, ADDR_W'($urandom));
        end
        check("rd_beats", got, BEATS);
        mem_cmd_in = NOP;
    endtask

    initial begin
        int         g_who [$];
        int         g_cyc [$];
        logic       prev_drive;
        logic [ADDR_W-1:0] a;
        int         who;

        // Reset state, with both requesters already asking.
        drive_req(0, WR, 16'h1111);
        drive_req(1, WR, 16'h2222);
        repeat (3) @(negedge clk);
        check_quiet("rst_outputs");
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;

        // Round-robin: both requesting every cycle from reset.
        prev_drive = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            check("rr_exclusive", {m0_grant & m1_grant, m0_wack & m1_wack}, 0);
            if (m0_grant || m1_grant) begin
                g_who.push_back(m1_grant ? 1 : 0);
                g_cyc.push_back(c);
                if (c > 1) check("rr_gap_drive", prev_drive, 0);
            end
            if (c >= 41) check_quiet("rr_tail");
            prev_drive = mem_drive;
            m0_wdata = DATA_W'($urandom);
            m1_wdata = DATA_W'($urandom);
            if (c == 35) begin
                drive_req(0, NOP, '0);
                drive_req(1, NOP, '0);
            end
        end
        check("rr_count", g_who.size(), 4);
        for (int i = 0; i < g_who.size() && i < 4; i++) begin
            check("rr_order", g_who[i], i % 2);
            check("rr_cycle", g_cyc[i], 1 + i * (BEATS + 2));
        end

        // m0 write line, beats 1..8.
        for (int i = 0; i < BEATS; i++) beat_data[i] = DATA_W'(i + 1);
        run_write(0, 16'h0003);

        // m1 read line, memory answers after 3 cycles with 0xA0..0xA7.
        for (int i = 0; i < BEATS; i++) beat_data[i] = DATA_W'(16'hA0 + i);
        run_read(1, 16'h0010, 3, 0);

        // Gapped responses, then a second read to show the beat count wrapped.
        for (int i = 0; i < BEATS; i++) beat_data[i] = DATA_W'($urandom);
        run_read(0, 16'h0042, 1, 1);
        for (int i = 0; i < BEATS; i++) beat_data[i] = DATA_W'($urandom);
        run_read(0, 16'h0043, 2, 0);

        // Reset during WRITE beat 4: abandoned without done, then m1 served.
        a = ADDR_W'($urandom);
        drive_req(0, WR, a);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive_wdata(0, DATA_W'(k));
        end
        #2 reset = 1'b1;
        #1 check_quiet("rst_mid_now");
        check("rst_mid_wdata", mem_wdata, 0);
        check("rst_mid_addr", mem_addr, 0);
        drive_req(0, NOP, '0);
        @(negedge clk);
        check_quiet("rst_mid_next");
        reset = 1'b0;
        for (int i = 0; i < BEATS; i++) beat_data[i] = DATA_W'($urandom);
        run_read(1, 16'h0077, 2, 0);

        // Randomised transfers.
        for (int t = 0; t < 8; t++) begin
            who = int'($urandom_range(0, 1));
            a   = ADDR_W'($urandom);
            for (int i = 0; i < BEATS; i++) beat_data[i] = DATA_W'($urandom);
            if ($urandom_range(0, 1) == 1) run_write(who, a);
            else run_read(who, a, int'($urandom_range(1, 5)), 2);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Read with no response: done and err TIMEOUT cycles after WAIT entry.
        drive_req(0, RD, 16'h0099);
        for (int k = 1; k <= TIMEOUT + 3; k++) begin
            @(negedge clk);
            check("to_owner", {sig_of(0), err},
                  {k == 1, 1'b0, 1'b0, k == TIMEOUT + 2, k == TIMEOUT + 2});
            if (k == 1) drive_req(0, NOP, '0);
        end
        check_quiet("to_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
